// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin arbiter driving a shared WIDTH-bit JK flip-flop bank
// Optional op_cnt completion counter: define JK_BANK_ARBITER_OPCNT_EN.
module jk_bank_arbiter #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] mask0,
  input  logic [LEN_W-1:0] len0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] mask1,
  input  logic [LEN_W-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
`ifdef JK_BANK_ARBITER_OPCNT_EN
  ,
  output logic [15:0]      op_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] bank_q, bank_d;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    op_d    = op_q;
    mask_d  = mask_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    j       = '0;
    k       = '0;
    case (state_q)
      IDLE: begin
        // rr_q == 1 means requester 1 wins a tie
        if (req0 && (!req1 || !rr_q)) begin
          op_d    = op0;
          mask_d  = mask0;
          len_d   = len0;
          gnt0_d  = 1'b1;
          rr_d    = 1'b1;
          cnt_d   = '0;
          state_d = APPLY;
        end else if (req1) begin
          op_d    = op1;
          mask_d  = mask1;
          len_d   = len1;
          gnt1_d  = 1'b1;
          rr_d    = 1'b0;
          cnt_d   = '0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        j = mask_q & {WIDTH{op_q[1]}};
        k = mask_q & {WIDTH{op_q[0]}};
        for (int i = 0; i < WIDTH; i++) begin
          case ({j[i], k[i]})
            2'b01:   bank_d[i] = 1'b0;
            2'b10:   bank_d[i] = 1'b1;
            2'b11:   bank_d[i] = ~bank_q[i];
            default: bank_d[i] = bank_q[i];
          endcase
        end
        // cnt_q holds the number of edges already applied, so compare before incrementing
        if (cnt_q == len_q) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      op_q    <= '0;
      mask_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
    end
  end

`ifdef JK_BANK_ARBITER_OPCNT_EN
  logic [15:0] op_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_cnt_q <= '0;
    end else if (state_q == DONE) begin
      op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign op_cnt = op_cnt_q;
`endif

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign q    = bank_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - scoreboard bench for jk_bank_arbiter
module tb_jk_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = '0, op1 = '0;
  logic [3:0] mask0 = '0, mask1 = '0;
  logic [2:0] len0 = '0, len1 = '0;
  logic       gnt0, gnt1, busy, done;
  logic [3:0] j, k, q;
`ifdef JK_BANK_ARBITER_OPCNT_EN
  logic [15:0] op_cnt;
  int          opc_exp = 0;
`endif

  jk_bank_arbiter #(.WIDTH(4), .LEN_W(3)) dut (
    .clk(clk), .reset(rst_n),
    .req0(req0), .op0(op0), .mask0(mask0), .len0(len0),
    .req1(req1), .op1(op1), .mask1(mask1), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .j(j), .k(k), .q(q)
`ifdef JK_BANK_ARBITER_OPCNT_EN
    , .op_cnt(op_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic was_apply = 1'b0;
  logic [3:0] q_m = '0;
  int   exp_gnt[$];
  logic [7:0] exp_jk[$];
  logic [3:0] exp_q[$];
  logic [3:0] exp_done[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] jk_next(input logic [3:0] qv, input logic [3:0] jv, input logic [3:0] kv);
    return (jv & ~qv) | (~kv & qv);
  endfunction

  task automatic push_cmd(input int who, input logic [1:0] op, input logic [3:0] mask, input logic [2:0] len);
    logic [3:0] jv, kv;
    jv = mask & {4{op[1]}};
    kv = mask & {4{op[0]}};
    exp_gnt.push_back(who);
    for (int i = 0; i <= int'(len); i++) begin
      exp_jk.push_back({jv, kv});
      q_m = jk_next(q_m, jv, kv);
      exp_q.push_back(q_m);
    end
    exp_done.push_back(q_m);
  endtask

  always @(negedge clk) begin
    logic apply_now;
    if (!rst_n) begin
      was_apply = 1'b0;
    end else begin
      if (was_apply) begin
        if (exp_q.size() == 0) chk("q_unexpected_update", 1, 0);
        else chk("q_after_apply", {28'd0, q}, {28'd0, exp_q.pop_front()});
      end
      if (gnt0 || gnt1) begin
        chk("gnt_both", {31'd0, gnt0 & gnt1}, 0);
        if (exp_gnt.size() == 0) chk("gnt_unexpected", 1, 0);
        else chk("gnt_id", {31'd0, gnt1}, exp_gnt.pop_front());
      end
      apply_now = busy && !done;
      if (apply_now) begin
        if (exp_jk.size() == 0) chk("jk_unexpected", 1, 0);
        else chk("jk_apply", {24'd0, j, k}, {24'd0, exp_jk.pop_front()});
      end else begin
        chk("jk_idle", {24'd0, j, k}, 0);
      end
      if (done) begin
        done_cnt++;
`ifdef JK_BANK_ARBITER_OPCNT_EN
        opc_exp++;
`endif
        chk("busy_in_done", {31'd0, busy}, 1);
        if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
        else chk("q_at_done", {28'd0, q}, {28'd0, exp_done.pop_front()});
      end
      was_apply = apply_now;
    end
  end

  task automatic set_req(input int who, input logic v, input logic [1:0] op, input logic [3:0] mask, input logic [2:0] len);
    if (who == 0) begin req0 = v; op0 = op; mask0 = mask; len0 = len; end
    else          begin req1 = v; op1 = op; mask1 = mask; len1 = len; end
  endtask

  task automatic send(input int who, input logic [1:0] op, input logic [3:0] mask, input logic [2:0] len);
    int lat, n;
    push_cmd(who, op, mask, len);
    set_req(who, 1'b1, op, mask, len);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (gnt0 || gnt1) break;
    end
    chk("gnt_latency", lat, 1);
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk("done_latency", n, int'(len) + 1);
    @(negedge clk);
    chk("busy_after", {31'd0, busy}, 0);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_count", done_cnt, target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_gnt.delete(); exp_jk.delete(); exp_q.delete(); exp_done.delete();
    q_m = '0;
`ifdef JK_BANK_ARBITER_OPCNT_EN
    opc_exp = 0;
`endif
  endtask

  initial begin
    int g, n, d0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_q", {28'd0, q}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_gnt", {30'd0, gnt0, gnt1}, 0);

    send(0, 2'b10, 4'b1111, 3'd0);
    send(1, 2'b01, 4'b1111, 3'd0);
    send(1, 2'b11, 4'b0001, 3'd2);
    send(0, 2'b10, 4'b1111, 3'd0);
    send(0, 2'b01, 4'b1010, 3'd0);
    chk("masked_clr_q", {28'd0, q}, 32'h5);
    send(1, 2'b00, 4'b1111, 3'd3);
    send(0, 2'b11, 4'b0000, 3'd1);
    send(1, 2'b11, 4'b0110, 3'd7);

    // contention from reset: both held, grants must alternate 0,1,0,1
    do_reset();
    set_req(0, 1'b1, 2'b11, 4'b0001, 3'd0);
    set_req(1, 1'b1, 2'b10, 4'b1000, 3'd1);
    push_cmd(0, 2'b11, 4'b0001, 3'd0);
    push_cmd(1, 2'b10, 4'b1000, 3'd1);
    push_cmd(0, 2'b11, 4'b0001, 3'd0);
    push_cmd(1, 2'b10, 4'b1000, 3'd1);
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    g = 0; n = 0;
    while (g < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (gnt0 || gnt1) g++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_grants", g, 4);
    wait_done(d0 + 4, 40);
    @(negedge clk);

    // pointer moves only on grants: 0 then 1 leaves it favouring 0
    send(0, 2'b10, 4'b0010, 3'd0);
    send(1, 2'b01, 4'b0001, 3'd0);
    repeat (5) @(negedge clk);
    push_cmd(0, 2'b11, 4'b0100, 3'd0);
    set_req(0, 1'b1, 2'b11, 4'b0100, 3'd0);
    set_req(1, 1'b1, 2'b10, 4'b1111, 3'd0);
    d0 = done_cnt;
    n = 0;
    while (!(gnt0 || gnt1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tie_gnt0", {31'd0, gnt0}, 1);
    req0 = 1'b0; req1 = 1'b0;
    wait_done(d0 + 1, 20);
    @(negedge clk);

    // abort mid-command
    push_cmd(0, 2'b11, 4'b1111, 3'd7);
    set_req(0, 1'b1, 2'b11, 4'b1111, 3'd7);
    n = 0;
    while (!gnt0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_gnt", {31'd0, gnt0}, 1);
    req0 = 1'b0;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_gnt.delete(); exp_jk.delete(); exp_q.delete(); exp_done.delete();
    q_m = '0;
`ifdef JK_BANK_ARBITER_OPCNT_EN
    opc_exp = 0;
`endif
    #1;
    chk("abort_q", {28'd0, q}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_jk", {24'd0, j, k}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    send(1, 2'b10, 4'b1001, 3'd1);
    chk("post_abort_q", {28'd0, q}, 32'h9);
    send(0, 2'b11, 4'b1111, 3'd0);

`ifdef JK_BANK_ARBITER_OPCNT_EN
    chk("op_cnt", {16'd0, op_cnt}, opc_exp);
`endif
    chk("left_gnt", exp_gnt.size(), 0);
    chk("left_q", exp_q.size(), 0);
    chk("left_done", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
